divider: RTL

//  Sequential unsigned restoring divider (shift-subtract), the inverse of the FPU's

---
 rtl/divider_pkg.sv | 23 ++
 rtl/div_step.sv | 48 ++++
 rtl/divider.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared FPU integer-datapath definitions used by the sequential divider.
//   Holds the default datapath width, which the shift-add multiplier also
//   uses, the iteration-counter width, and the divider FSM state encoding.
//
//   Contents:
//     FPU_WIDTH    default operand/result width of the integer datapath
//     DIV_CNT_W    default divider iteration-counter width (2**DIV_CNT_W > FPU_WIDTH)
//     div_state_e  divider FSM states: DIV_IDLE, DIV_RUN, DIV_DONE
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int FPU_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : divider_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational iteration of an unsigned restoring divider.
//   The partial remainder is shifted left by one and takes in the top bit of
//   the working quotient. The divisor is then trial-subtracted. If the result
//   is not negative, it becomes the new remainder and a 1 enters the quotient
//   LSB. Otherwise the shifted value is kept and a 0 enters the quotient LSB.
//
//   Ports:
//     rem_i      in   WIDTH  partial remainder, always < divisor_i
//     quo_i      in   WIDTH  working quotient; unconsumed dividend bits at the top
//     divisor_i  in   WIDTH  divisor, nonzero
//     rem_o      out  WIDTH  updated partial remainder
//     quo_o      out  WIDTH  quotient shifted left, with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder needs WIDTH+1 bits: rem_i < divisor_i, so
    // 2*rem_i+1 can reach 2**WIDTH.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // NOTE: every output gets a default before the conditional
        // override, so no path leaves a signal unassigned and no latch
        // is inferred.
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], 1'b0};
        // The top bit of the difference is the borrow. When it is clear,
        // shifted >= divisor and the subtraction is kept. The restored
        // remainder stays < divisor, so the top bit can be dropped safely.
        if (!diff[WIDTH]) begin
            rem_o    = diff[WIDTH-1:0];
            quo_o[0] = 1'b1;
        end
    end

endmodule : div_step

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Sequential unsigned restoring (shift-subtract) divider. It produces one
//   quotient bit per clock and always takes exactly WIDTH iterations. It sits
//   beside the shift-add multiplier in the FPU integer datapath.
//
//   Ports:
//     clk          in   1      rising-edge clock
//     reset        in   1      synchronous, active-high reset
//     start        in   1      request; only accepted while ready=1
//     opA          in   WIDTH  dividend, captured on an accepted start
//     opB          in   WIDTH  divisor, captured on an accepted start
//     ready        out  1      high in IDLE and DONE, low while iterating
//     quotient     out  WIDTH  result quotient, held until the next result
//     remainder    out  WIDTH  result remainder, held until the next result
//     res_ok       out  1      one-cycle pulse: result valid
//     div_by_zero  out  1      qualifies res_ok: the captured divisor was 0
//
//   Timing: a start accepted at edge N gives res_ok in the cycle after edge
//   N+WIDTH. A zero divisor skips the iterations: the FSM goes straight to
//   DONE on the accepting edge. Another start may be accepted in DONE, so
//   operations can run back to back.
// -----------------------------------------------------------------------------
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = FPU_WIDTH,
    // Must satisfy 2**CNT_W > WIDTH so the counter can reach WIDTH-1.
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             res_ok,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // FSM and iteration state
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    // Working registers, kept separate from the outputs so the published
    // result does not move while an operation is iterating. The stored
    // partial remainder is WIDTH bits wide because it is always < divisor.
    // The extra bit needed for the shift exists only inside div_step.
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quo_w_q;
    logic [WIDTH-1:0] rem_w_q;

    // Next working values from one restoring iteration
    logic [WIDTH-1:0] quo_w_d;
    logic [WIDTH-1:0] rem_w_d;

    // Registered outputs
    logic             ready_q;
    logic             res_ok_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_w_q),
        .quo_i     (quo_w_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_w_d),
        .quo_o     (quo_w_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            quo_w_q   <= '0;
            rem_w_q   <= '0;
            ready_q   <= 1'b1;
            res_ok_q  <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            // res_ok is a single-cycle pulse unless a result is produced below
            res_ok_q <= 1'b0;

            case (state_q)
                DIV_IDLE, DIV_DONE: begin
                    if (start) begin
                        divisor_q <= opB;
                        quo_w_q   <= opA;
                        rem_w_q   <= '0;
                        cnt_q     <= '0;
                        dbz_q     <= (opB == '0);
                        if (opB == '0) begin
                            // A zero divisor has a defined result and needs
                            // no iterations.
                            state_q  <= DIV_DONE;
                            ready_q  <= 1'b1;
                            res_ok_q <= 1'b1;
                            quot_q   <= '1;
                            rem_q    <= opA;
                        end else begin
                            state_q <= DIV_RUN;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= DIV_IDLE;
                        ready_q <= 1'b1;
                    end
                end

                DIV_RUN: begin
                    rem_w_q <= rem_w_d;
                    quo_w_q <= quo_w_d;
                    cnt_q   <= cnt_q + 1'b1;
                    // The latency is fixed: stop only after the last of
                    // WIDTH iterations. On this final edge, the step result
                    // goes directly to the outputs.
                    if (cnt_q == LAST_ITER) begin
                        state_q  <= DIV_DONE;
                        ready_q  <= 1'b1;
                        res_ok_q <= 1'b1;
                        quot_q   <= quo_w_d;
                        rem_q    <= rem_w_d;
                    end
                end

                default: begin
                    state_q <= DIV_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign res_ok      = res_ok_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule : divider
